// File: rtl/bin_search_4bit_pkg.sv
// Shared definitions for the comparator-driven binary search controller:
// state encoding and search-space limits.
package bin_search_4bit_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_SW    = 3;
    localparam int MAX_VAL   = (1 << DEF_WIDTH) - 1;
    localparam int MAX_STEPS = DEF_WIDTH + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_PROBE = 1'b1
    } state_e;

endpackage

// File: rtl/bin_search_mid.sv
// Combinational midpoint of an extended-width [lo, hi] range, truncated to the
// operand width.
module bin_search_mid
    import bin_search_4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   lo,
    input  logic [WIDTH:0]   hi,
    output logic [WIDTH-1:0] mid
);

    logic [WIDTH+1:0] sum_s;

    // One extra bit keeps the carry of lo+hi before halving.
    assign sum_s = {1'b0, lo} + {1'b0, hi};
    assign mid   = WIDTH'(sum_s >> 1);

endmodule

// File: rtl/comparator4bit.sv
// 4-bit magnitude comparator: flags w0 relative to w1.
module comparator4bit (
    input  logic [3:0] w0,
    input  logic [3:0] w1,
    output logic       less,
    output logic       equal,
    output logic       greater
);

    assign less    = (w0 < w1);
    assign equal   = (w0 == w1);
    assign greater = (w0 > w1);

endmodule

// File: rtl/bin_search_4bit.sv
// Binary-search controller: probes a comparator with a registered guess and
// narrows [lo, hi] from the less/equal/greater flags until it hits or empties.
module bin_search_4bit
    import bin_search_4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SW    = DEF_SW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps
);

    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE_W      = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [SW-1:0]    STEP_CAP   = SW'(MAX_STEPS);
    localparam logic [SW-1:0]    STEP_ONE   = {{(SW-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [WIDTH:0]   lo_r;
    logic [WIDTH:0]   hi_r;
    logic [WIDTH:0]   guess_ext_s;
    logic [WIDTH:0]   lo_up_s;
    logic [WIDTH:0]   hi_dn_s;
    logic             empty_up_s;
    logic             empty_dn_s;
    logic [2:0]       flags_s;
    logic [WIDTH:0]   mid_lo_s;
    logic [WIDTH:0]   mid_hi_s;
    logic [WIDTH-1:0] mid_s;
    logic [SW-1:0]    steps_inc_s;

    assign guess_ext_s = {1'b0, guess};
    assign lo_up_s     = guess_ext_s + ONE_W;
    // hi_dn_s wraps when guess is 0; empty_dn_s flags that case before it is used.
    assign hi_dn_s     = guess_ext_s - ONE_W;
    assign empty_up_s  = (guess_ext_s >= hi_r);
    assign empty_dn_s  = (lo_r >= guess_ext_s);
    assign flags_s     = {less, equal, greater};

    // Select the range that the next probe will bisect.
    always_comb begin
        mid_lo_s = lo_r;
        mid_hi_s = hi_dn_s;
        if (greater) begin
            mid_lo_s = lo_up_s;
            mid_hi_s = hi_r;
        end else begin
            mid_lo_s = lo_r;
            mid_hi_s = hi_dn_s;
        end
    end

    // Saturating probe counter.
    always_comb begin
        steps_inc_s = steps;
        if (steps == STEP_CAP) begin
            steps_inc_s = steps;
        end else begin
            steps_inc_s = steps + STEP_ONE;
        end
    end

    bin_search_mid #(.WIDTH(WIDTH)) u_mid (
        .lo  (mid_lo_s),
        .hi  (mid_hi_s),
        .mid (mid_s)
    );

    // Search FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            lo_r    <= {(WIDTH+1){1'b0}};
            hi_r    <= HI_INIT;
            guess   <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            found   <= 1'b0;
            result  <= {WIDTH{1'b0}};
            steps   <= {SW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        lo_r    <= {(WIDTH+1){1'b0}};
                        hi_r    <= HI_INIT;
                        guess   <= GUESS_INIT;
                        steps   <= {SW{1'b0}};
                        found   <= 1'b0;
                        result  <= {WIDTH{1'b0}};
                        busy    <= 1'b1;
                        state_r <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    steps <= steps_inc_s;
                    case (flags_s)
                        3'b010: begin
                            found   <= 1'b1;
                            result  <= guess;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= S_IDLE;
                        end
                        3'b001: begin
                            if (empty_up_s) begin
                                found   <= 1'b0;
                                result  <= guess;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_r <= S_IDLE;
                            end else begin
                                lo_r  <= lo_up_s;
                                guess <= mid_s;
                            end
                        end
                        3'b100: begin
                            if (empty_dn_s) begin
                                found   <= 1'b0;
                                result  <= guess;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_r <= S_IDLE;
                            end else begin
                                hi_r  <= hi_dn_s;
                                guess <= mid_s;
                            end
                        end
                        default: begin
                            found   <= 1'b0;
                            result  <= guess;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= S_IDLE;
                        end
                    endcase
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
